// File: rtl/matriz_determ_nxn_pkg.sv
// determ_pkg: shared types and helpers for the runtime-sized determinant unit.
//   state_e  : controller states (IDLE, PROD, ACCUM, NEXT, FIN)
//   CNT_W    : width of the order, row counter and Heap counters (n is 3 bits)
//   idx_w    : width of one permutation entry, clog2(N_MAX)
//   elem_off : bit offset of element (r,c) inside the packed matrix bus
package determ_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROD,
        ST_ACCUM,
        ST_NEXT,
        ST_FIN
    } state_e;

    localparam int CNT_W = 3;

    function automatic int idx_w(input int nmax);
        return (nmax < 2) ? 1 : $clog2(nmax);
    endfunction

    function automatic int elem_off(input int r, input int c, input int nmax, input int w);
        return (r * nmax + c) * w;
    endfunction

endpackage

// File: rtl/matriz_determ_nxn_if.sv
// matriz_determ_nxn_if: request/result bundle of the determinant unit.
//   start  : one-cycle request pulse (master -> slave)
//   n      : matrix order for the request
//   matrix : packed elements, (r,c) at [(r*N_MAX+c)*W +: W]
//   busy   : operation in progress
//   done   : one-cycle result-valid pulse
//   err    : order out of range, valid with done
//   det    : signed determinant, modulo 2^ACC_W
interface matriz_determ_nxn_if #(
    parameter int N_MAX = 5,
    parameter int W     = 8,
    parameter int ACC_W = 32
) ();
    logic                     start;
    logic [2:0]               n;
    logic [N_MAX*N_MAX*W-1:0] matrix;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [ACC_W-1:0]         det;

    modport master (output start, n, matrix, input busy, done, err, det);
    modport slave  (input start, n, matrix, output busy, done, err, det);
endinterface

// File: rtl/matriz_determ_nxn_heap.sv
// heap_perm_gen: iterative Heap's-algorithm permutation enumerator.
//   clk, reset : clock, synchronous active-high reset
//   init       : restart at the identity permutation, sign positive
//   step       : perform one Heap iteration this cycle
//   n          : active order
//   perm       : packed permutation, entry k at [k*IDX_W +: IDX_W]
//   sign       : 1 when the current permutation is odd
//   last       : enumeration exhausted (i has reached n)
//   step_done  : the iteration taken this cycle produces a new permutation
module heap_perm_gen
    import determ_pkg::*;
#(
    parameter int N_MAX = 5,
    parameter int IDX_W = idx_w(N_MAX)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   step,
    input  logic [CNT_W-1:0]       n,
    output logic [N_MAX*IDX_W-1:0] perm,
    output logic                   sign,
    output logic                   last,
    output logic                   step_done
);

    logic [IDX_W-1:0] perm_q [N_MAX];
    logic [IDX_W-1:0] perm_d [N_MAX];
    logic [CNT_W-1:0] c_q    [N_MAX];
    logic [CNT_W-1:0] c_d    [N_MAX];
    logic [CNT_W-1:0] i_q;
    logic [CNT_W-1:0] j_idx;
    logic [CNT_W-1:0] c_i_sel;
    logic [IDX_W-1:0] perm_i_sel;
    logic [IDX_W-1:0] perm_j_sel;
    logic             sign_q;
    logic             found;

    // Muxes instead of direct i/j indexing keep every read in range even
    // when i has run up to n == N_MAX.
    always_comb begin
        perm_i_sel = '0;
        perm_j_sel = '0;
        c_i_sel    = '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (CNT_W'(k) == i_q) begin
                perm_i_sel = perm_q[k];
                c_i_sel    = c_q[k];
            end
        end
        // Swap partner: slot 0 for even i, slot c[i] for odd i.
        j_idx = i_q[0] ? c_i_sel : '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (CNT_W'(k) == j_idx) begin
                perm_j_sel = perm_q[k];
            end
        end
        last  = (i_q >= n);
        found = !last && (c_i_sel < i_q);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_MAX; gi++) begin : g_slot
            assign perm[gi*IDX_W +: IDX_W] = perm_q[gi];
            assign perm_d[gi] = !found                 ? perm_q[gi] :
                                (CNT_W'(gi) == i_q)    ? perm_j_sel :
                                (CNT_W'(gi) == j_idx)  ? perm_i_sel : perm_q[gi];
            assign c_d[gi]    = (CNT_W'(gi) != i_q) ? c_q[gi] :
                                found               ? c_i_sel + CNT_W'(1) : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || init) begin
            for (int k = 0; k < N_MAX; k++) begin
                perm_q[k] <= IDX_W'(k);
                c_q[k]    <= '0;
            end
            i_q    <= CNT_W'(1);
            sign_q <= 1'b0;
        end else if (step && !last) begin
            perm_q <= perm_d;
            c_q    <= c_d;
            // Each swap is one transposition, so parity simply alternates.
            if (found) begin
                i_q    <= CNT_W'(1);
                sign_q <= ~sign_q;
            end else begin
                i_q    <= i_q + CNT_W'(1);
            end
        end
    end

    assign sign      = sign_q;
    assign step_done = found;

endmodule

// File: rtl/matriz_determ_nxn.sv
// matriz_determ_nxn: serial Leibniz-expansion determinant of an n x n signed
// matrix (1 <= n <= N_MAX), one permutation term at a time through a single
// multiplier. Arithmetic wraps modulo 2^ACC_W.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of matriz_determ_nxn_if (start/n/matrix in,
//           busy/done/err/det out)
module matriz_determ_nxn
    import determ_pkg::*;
#(
    parameter int N_MAX = 5,
    parameter int W     = 8,
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    matriz_determ_nxn_if.slave  bus
);

    localparam int IDX_W = idx_w(N_MAX);

    state_e                   state_q;
    logic [N_MAX*N_MAX*W-1:0] a_q;
    logic [CNT_W-1:0]         n_q;
    logic [CNT_W-1:0]         k_q;
    logic [ACC_W-1:0]         prod_q;
    logic [ACC_W-1:0]         prod_d;
    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         det_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic [N_MAX*IDX_W-1:0]   perm_flat;
    logic                     perm_sign;
    logic                     heap_last;
    logic                     heap_found;
    logic                     heap_init;
    logic                     heap_step;

    logic signed [W-1:0]      a_elem [N_MAX][N_MAX];
    logic [IDX_W-1:0]         perm_k;
    logic signed [W-1:0]      elem_sel;
    logic [ACC_W-1:0]         elem_ext;
    logic [ACC_W-1:0]         mul_a;
    logic                     n_ok;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_MAX; gi++) begin : g_row
            for (gj = 0; gj < N_MAX; gj++) begin : g_col
                assign a_elem[gi][gj] = a_q[elem_off(gi, gj, N_MAX, W) +: W];
            end
        end
    endgenerate

    always_comb begin
        perm_k = '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (CNT_W'(k) == k_q) perm_k = perm_flat[k*IDX_W +: IDX_W];
        end
        elem_sel = '0;
        for (int r = 0; r < N_MAX; r++) begin
            for (int c = 0; c < N_MAX; c++) begin
                if (CNT_W'(r) == k_q && IDX_W'(c) == perm_k) elem_sel = a_elem[r][c];
            end
        end
        elem_ext = ACC_W'(elem_sel);
        // Seeding the multiplier with 1 on the first row lets the same
        // multiplier load a[0][perm[0]]; only the low ACC_W bits are kept,
        // so unsigned multiply of the sign-extended operand is exact mod 2^ACC_W.
        mul_a  = (k_q == '0) ? ACC_W'(1) : prod_q;
        prod_d = mul_a * elem_ext;
    end

    assign n_ok      = (bus.n != '0) && (bus.n <= CNT_W'(N_MAX));
    assign heap_init = (state_q == ST_IDLE) && bus.start;
    assign heap_step = (state_q == ST_NEXT);

    heap_perm_gen #(
        .N_MAX (N_MAX),
        .IDX_W (IDX_W)
    ) u_heap (
        .clk       (clk),
        .reset     (reset),
        .init      (heap_init),
        .step      (heap_step),
        .n         (n_q),
        .perm      (perm_flat),
        .sign      (perm_sign),
        .last      (heap_last),
        .step_done (heap_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            det_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.matrix;
                        n_q    <= bus.n;
                        k_q    <= '0;
                        prod_q <= '0;
                        acc_q  <= '0;
                        if (n_ok) begin
                            state_q <= ST_PROD;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            // Bad order: report straight away, nothing to compute.
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            det_q   <= '0;
                        end
                    end
                end
                ST_PROD: begin
                    prod_q <= prod_d;
                    k_q    <= k_q + CNT_W'(1);
                    if (k_q == n_q - CNT_W'(1)) state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc_q   <= perm_sign ? acc_q - prod_q : acc_q + prod_q;
                    k_q     <= '0;
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (heap_last) begin
                        state_q <= ST_FIN;
                        det_q   <= acc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (heap_found) begin
                        state_q <= ST_PROD;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.det  = det_q;

endmodule

// File: tb/tb_matriz_determ_nxn.sv
module tb_matriz_determ_nxn;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matriz_determ_nxn_if #(.N_MAX(5), .W(8), .ACC_W(32)) if0 ();
    matriz_determ_nxn_if #(.N_MAX(5), .W(8), .ACC_W(8))  if8 ();

    matriz_determ_nxn #(.N_MAX(5), .W(8), .ACC_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    matriz_determ_nxn #(.N_MAX(5), .W(8), .ACC_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    typedef struct packed {
        logic [31:0] det;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q8[$];
    exp_t e0;
    exp_t e8;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mat [5][5];
    bit   sel8 = 1'b0;
    logic cur_done;
    logic cur_busy;

    assign cur_done = sel8 ? if8.done : if0.done;
    assign cur_busy = sel8 ? if8.busy : if0.busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: one result popped per done pulse.
    always @(negedge clk) begin
        if (if0.done === 1'b1) begin
            check("sb32_pending", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check("det32", if0.det, e0.det);
                check("err32", 32'(if0.err), 32'(e0.err));
                $display("[TB] acc32 result det=%0d err=%0b", $signed(if0.det), if0.err);
            end
        end
    end

    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            check("sb8_pending", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("det8", 32'(if8.det), e8.det);
                check("err8", 32'(if8.err), 32'(e8.err));
                $display("[TB] acc8 result det=%0d err=%0b", $signed(if8.det), if8.err);
            end
        end
    end

    function automatic logic [199:0] pack_mat();
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v[(r*5+c)*8 +: 8] = 8'(mat[r][c]);
        return v;
    endfunction

    // Reference determinant by fraction-free (Bareiss) elimination.
    function automatic longint ref_det(input int nn);
        longint a [5][5];
        longint prev, sgn, t;
        int     p;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                a[r][c] = longint'(mat[r][c]);
        sgn  = 1;
        prev = 1;
        for (int k = 0; k < nn - 1; k++) begin
            if (a[k][k] == 0) begin
                p = -1;
                for (int r = k + 1; r < nn; r++)
                    if (p < 0 && a[r][k] != 0) p = r;
                if (p < 0) return 0;
                for (int c = 0; c < 5; c++) begin
                    t = a[k][c]; a[k][c] = a[p][c]; a[p][c] = t;
                end
                sgn = -sgn;
            end
            for (int i = k + 1; i < nn; i++)
                for (int j = k + 1; j < nn; j++)
                    a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
            prev = a[k][k];
        end
        return sgn * a[nn-1][nn-1];
    endfunction

    function automatic int lat_bound(input int nn);
        int f;
        if (nn < 1 || nn > 5) return 4;
        f = 1;
        for (int i = 2; i <= nn; i++) f = f * i;
        return f * (nn + 3) + 4;
    endfunction

    task automatic drive(input bit s, input logic [2:0] nn, input logic [199:0] m);
        if (sel8) begin
            if8.start = s; if8.n = nn; if8.matrix = m;
        end else begin
            if0.start = s; if0.n = nn; if0.matrix = m;
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mat[r][c] = int'($urandom_range(40)) - 20;
    endtask

    task automatic run_op(input int nn, input longint exp_det, input bit exp_err,
                          input bit disturb, input string tag);
        int           lat;
        int           busy_cyc;
        logic [199:0] m;
        exp_t         e;
        m     = pack_mat();
        e.det = sel8 ? 32'(exp_det[7:0]) : exp_det[31:0];
        e.err = exp_err;
        @(negedge clk);
        drive(1'b1, 3'(nn), m);
        if (sel8) q8.push_back(e); else q0.push_back(e);
        @(negedge clk);
        drive(1'b0, 3'(nn), m);
        lat      = 1;
        busy_cyc = cur_busy ? 1 : 0;
        if (!exp_err) check({tag, "_busy"}, 32'(cur_busy), 32'd1);
        while (!cur_done && lat < 2000) begin
            // A second request and a new matrix while busy must be ignored.
            if (disturb && lat == 3) drive(1'b1, 3'd2, ~m);
            else if (disturb && lat == 4) drive(1'b0, 3'd2, ~m);
            @(negedge clk);
            lat++;
            if (cur_busy) busy_cyc++;
        end
        check({tag, "_done_seen"}, 32'(cur_done), 32'd1);
        if (!cur_done) begin
            if (sel8) q8.delete(); else q0.delete();
        end
        check({tag, "_latency_ok"}, 32'(lat <= lat_bound(nn)), 32'd1);
        check({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
        if (exp_err) check({tag, "_busy_cycles"}, 32'(busy_cyc <= 2), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
        $display("[TB] op %s n=%0d latency=%0d", tag, nn, lat);
    endtask

    initial begin
        reset      = 1'b1;
        if0.start  = 1'b0; if0.n = '0; if0.matrix = '0;
        if8.start  = 1'b0; if8.n = '0; if8.matrix = '0;
        repeat (3) @(negedge clk);
        check("rst_busy32", 32'(if0.busy), 32'd0);
        check("rst_done32", 32'(if0.done), 32'd0);
        check("rst_err32",  32'(if0.err),  32'd0);
        check("rst_det32",  if0.det,       32'd0);
        check("rst_busy8",  32'(if8.busy), 32'd0);
        check("rst_det8",   32'(if8.det),  32'd0);
        reset = 1'b0;

        sel8 = 1'b0;
        // Unused rows/columns carry junk that must not affect the result.
        mat = '{'{3, 8, 9, -5, 1}, '{4, 6, 7, 7, 7}, '{1, 2, 3, 4, 5},
                '{9, 9, 9, 9, 9}, '{-1, -2, -3, -4, -5}};
        run_op(2, -14, 1'b0, 1'b0, "n2");

        mat = '{'{2, -1, 0, 11, 12}, '{1, 3, 4, 13, 14}, '{0, 5, -2, 15, 16},
                '{7, 7, 7, 7, 7}, '{8, 8, 8, 8, 8}};
        run_op(3, -54, 1'b0, 1'b0, "n3");

        mat = '{'{2, 1, 7, -3, 5}, '{0, 3, 2, 6, -1}, '{0, 0, 1, 4, 2},
                '{0, 0, 0, 4, -8}, '{0, 0, 0, 0, 5}};
        run_op(5, 120, 1'b0, 1'b0, "upper_tri");

        mat = '{'{1, 2, 3, 4, 5}, '{-2, 7, 0, 1, 9}, '{3, -4, 6, 2, -1},
                '{-2, 7, 0, 1, 9}, '{5, 0, -3, 8, 2}};
        run_op(5, 0, 1'b0, 1'b0, "dup_row");

        mat = '{'{1, 0, 0, 0, 0}, '{0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0},
                '{0, 0, 0, 1, 0}, '{0, 0, 0, 0, 1}};
        run_op(5, 1, 1'b0, 1'b0, "identity");

        mat = '{'{-7, 4, 4, 4, 4}, '{4, 4, 4, 4, 4}, '{4, 4, 4, 4, 4},
                '{4, 4, 4, 4, 4}, '{4, 4, 4, 4, 4}};
        run_op(1, -7, 1'b0, 1'b0, "n1");

        run_op(0, 0, 1'b1, 1'b0, "n0_err");
        run_op(6, 0, 1'b1, 1'b0, "n6_err");

        fill_random();
        run_op(4, ref_det(4), 1'b0, 1'b1, "restart_ignored");

        // Reset in the middle of the product phase discards the operation.
        fill_random();
        @(negedge clk);
        drive(1'b1, 3'd5, pack_mat());
        @(negedge clk);
        drive(1'b0, 3'd5, pack_mat());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(if0.busy), 32'd0);
        check("midrst_done", 32'(if0.done), 32'd0);
        check("midrst_err",  32'(if0.err),  32'd0);
        check("midrst_det",  if0.det,       32'd0);
        reset = 1'b0;
        run_op(5, ref_det(5), 1'b0, 1'b0, "after_reset");

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_op(2 + (t % 4), ref_det(2 + (t % 4)), 1'b0, 1'b0, "random");
        end

        sel8 = 1'b1;
        mat = '{'{100, 0, 0, 0, 0}, '{0, 3, 0, 0, 0}, '{0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
        run_op(2, 44, 1'b0, 1'b0, "acc8_wrap");
        fill_random();
        run_op(3, ref_det(3), 1'b0, 1'b0, "acc8_random");

        repeat (4) @(negedge clk);
        check("sb32_drained", q0.size(), 32'd0);
        check("sb8_drained",  q8.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
